// File: rtl/calc1_pkg.sv
// Shared encodings for the calc1 port: command codes, response codes and driver FSM states.
package calc1_pkg;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE    = 2'd0;
    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_ERR     = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    localparam int unsigned TIMER_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSendOp1,
        StSendOp2,
        StWaitResp,
        StHoldRsp
    } state_e;

endpackage

// File: rtl/calc1_wait_timer.sv
// Response wait counter: clear has priority over enable; expired_o flags the last allowed cycle.
module calc1_wait_timer
    import calc1_pkg::*;
#(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LastCount = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LastCount);

endmodule

// File: rtl/calc1_port_driver.sv
// Serialises a {cmd, op1, op2} request onto one calc1 port and returns {resp, data},
// with a bounded wait for the port's answer.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CMD_W   = 4,
    parameter int unsigned RESP_W  = 2,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    output logic [CMD_W-1:0]  calc_cmd,
    output logic [DATA_W-1:0] calc_data,
    input  logic [RESP_W-1:0] calc_resp,
    input  logic [DATA_W-1:0] calc_out_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RESP_W-1:0] rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              spurious_resp
);

    state_e state_q, state_d;

    logic [DATA_W-1:0] op2_q, op2_d;
    logic              req_ready_q, req_ready_d;
    logic [CMD_W-1:0]  calc_cmd_q, calc_cmd_d;
    logic [DATA_W-1:0] calc_data_q, calc_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RESP_W-1:0] rsp_code_q, rsp_code_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;
    logic              spurious_q, spurious_d;

    logic accept;
    logic resp_seen;
    logic tmr_expired;

    assign accept    = (state_q == StIdle) && req_valid && req_ready_q;
    assign resp_seen = (calc_resp != '0);

    calc1_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (c_clk),
        .rst_i     (reset),
        .clr_i     (state_q == StSendOp2),
        .en_i      (state_q == StWaitResp),
        .expired_o (tmr_expired)
    );

    // State register plus the latched second operand
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q <= StIdle;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            op2_q   <= op2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (accept) state_d = StSendOp1;
            StSendOp1:  state_d = StSendOp2;
            StSendOp2:  state_d = StWaitResp;
            StWaitResp: if (resp_seen || tmr_expired) state_d = StHoldRsp;
            StHoldRsp:  if (rsp_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // calc_cmd_q/calc_data_q double as the latched command and first operand.
    always_comb begin
        op2_d       = op2_q;
        req_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        calc_cmd_d  = '0;
        calc_data_d = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_code_d  = rsp_code_q;
        rsp_data_d  = rsp_data_q;
        spurious_d  = spurious_q | (resp_seen && (state_q != StWaitResp));
        case (state_q)
            StIdle: begin
                if (accept) begin
                    calc_cmd_d  = req_cmd;
                    calc_data_d = req_op1;
                    op2_d       = req_op2;
                end
            end
            StSendOp1: calc_data_d = op2_q;
            StWaitResp: begin
                // A real response beats a timeout landing on the same cycle
                if (resp_seen) begin
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = calc_resp;
                    rsp_data_d  = calc_out_data;
                end else if (tmr_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RESP_W'(RESP_TIMEOUT);
                    rsp_data_d  = '0;
                end
            end
            StHoldRsp: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            req_ready_q <= 1'b0;
            calc_cmd_q  <= '0;
            calc_data_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            req_ready_q <= req_ready_d;
            calc_cmd_q  <= calc_cmd_d;
            calc_data_q <= calc_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            spurious_q  <= spurious_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign calc_cmd      = calc_cmd_q;
    assign calc_data     = calc_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_code      = rsp_code_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = busy_q;
    assign spurious_resp = spurious_q;

endmodule
